// File: rtl/alu_funct_pkg.sv
// Shared funct-code constants and the multiplier's FSM state encoding.
// The ALU and the HI/LO multiply unit both import this package, so one
// decoder can drive both blocks.
package alu_funct_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // MIPS R-type funct codes understood by the execute stage.
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_hilo_unit_datapath.sv
// Shift-add datapath: product accumulator, shifting multiplicand and
// multiplier, and the iteration counter. Flags the final iteration.
module multu_datapath
  import alu_funct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // Running sum including this iteration's conditional add; the top
  // captures it into HI/LO on the last iteration.
  always_comb begin
    sum  = mplier[0] ? (prod + mcand) : prod;
    last = (cnt == LAST_CNT);
  end

  // Load operands at launch, then advance one shift-add step per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      prod   <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential 32x32 unsigned multiplier with HI/LO result registers and
// MFHI/MFLO readback mux.
//
// Handshake: a multiply launches when start=1 and Signal=MULTU are seen
// at a rising edge while idle; busy is high for exactly WIDTH cycles,
// then done pulses for one cycle as HI/LO become valid. start while busy
// or done is dropped, never queued. dataOut is purely combinational on
// Signal and is not qualified by start.
module multu_hilo_unit
  import alu_funct_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output state_t           state_dbg
);

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               step;
  logic               write_hilo;
  logic [2*WIDTH-1:0] sum;
  logic               last;

  multu_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .a     (dataA),
    .b     (dataB),
    .sum   (sum),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    write_hilo = 1'b0;
    case (state)
      IDLE: begin
        if (start && (Signal == MULTU)) begin
          load       = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          write_hilo = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // HI/LO hold the previous result until the final iteration edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (write_hilo) begin
      hi <= sum[2*WIDTH-1:WIDTH];
      lo <= sum[WIDTH-1:0];
    end
  end

  // MFHI/MFLO readback; any other code reads zero.
  always_comb begin
    dataOut = '0;
    case (Signal)
      MFHI:    dataOut = hi;
      MFLO:    dataOut = lo;
      default: dataOut = '0;
    endcase
  end

  assign busy      = (state == MUL);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: inputs driven and outputs sampled
// on the falling edge, expected values hand-computed.
module tb_multu_hilo_unit;
  import alu_funct_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;
  logic [31:0] hi;
  logic [31:0] lo;
  state_t      state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Signal    (Signal),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .done      (done),
    .dataOut   (dataOut),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch a multiply and watch busy/done for a bounded window.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output int done_pulses,
                         output int done_at);
    @(negedge clk);
    start  = 1'b1;
    Signal = MULTU;
    dataA  = a;
    dataB  = b;
    @(negedge clk);
    start  = 1'b0;
    Signal = ADD;
    dataA  = 32'hDEAD_BEEF;
    dataB  = 32'h1234_5678;
    busy_cycles = 0;
    done_pulses = 0;
    done_at     = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
  endtask

  int bc, dp, da;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    Signal = ADD;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    Signal = MFLO;
    #1;
    check("reset_mflo", dataOut, 32'd0);
    rst_n = 1'b1;

    // 3 x 5
    run_mul(32'd3, 32'd5, bc, dp, da);
    check("3x5_busy_cycles", bc, 32'd32);
    check("3x5_done_pulses", dp, 32'd1);
    check("3x5_done_at", da, 32'd32);
    check("3x5_hi", hi, 32'h0000_0000);
    check("3x5_lo", lo, 32'h0000_000F);
    Signal = MFLO; #1;
    check("3x5_mflo", dataOut, 32'h0000_000F);
    Signal = MFHI; #1;
    check("3x5_mfhi", dataOut, 32'h0000_0000);

    // Max operands
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dp, da);
    check("max_done_pulses", dp, 32'd1);
    check("max_hi", hi, 32'hFFFF_FFFE);
    check("max_lo", lo, 32'h0000_0001);

    // Carry into HI
    run_mul(32'h8000_0000, 32'd2, bc, dp, da);
    check("carry_hi", hi, 32'h0000_0001);
    check("carry_lo", lo, 32'h0000_0000);

    // Zero operand
    run_mul(32'd0, 32'h1234_5678, bc, dp, da);
    check("zero_hi", hi, 32'h0000_0000);
    check("zero_lo", lo, 32'h0000_0000);

    // Non-zero result so reset visibly clears HI/LO
    run_mul(32'h0001_0000, 32'h0003_0005, bc, dp, da);
    check("pre_rst_hi", hi, 32'h0000_0003);
    check("pre_rst_lo", lo, 32'h0005_0000);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; Signal = MULTU; dataA = 32'd7; dataB = 32'd9;
    @(negedge clk);
    start = 1'b0; Signal = ADD;
    repeat (9) @(negedge clk);
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dp = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dp++;
      @(negedge clk);
    end
    check("midrst_no_activity", dp, 32'd0);
    run_mul(32'd7, 32'd9, bc, dp, da);
    check("after_rst_lo", lo, 32'd63);
    check("after_rst_done_pulses", dp, 32'd1);

    // Start ignored while busy; MFLO during busy returns prior LO
    @(negedge clk);
    start = 1'b1; Signal = MULTU; dataA = 32'd6; dataB = 32'd7;
    @(negedge clk);
    start = 1'b0; Signal = ADD;
    dp = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) dp++;
      if (i == 6) check("busy_mflo_prior", dataOut, 32'd63);
      if (i == 4) begin
        start = 1'b1; Signal = MULTU; dataA = 32'd4; dataB = 32'd4;
      end else if (i == 5) begin
        start = 1'b0; Signal = MFLO;
      end
      @(negedge clk);
      #1;
    end
    check("ignore_busy_cycles", bc, 32'd32);
    check("ignore_done_pulses", dp, 32'd1);
    check("ignore_lo", lo, 32'd42);
    check("ignore_hi", hi, 32'd0);

    // dataOut mux
    Signal = MFLO; #1;
    check("mux_mflo", dataOut, 32'd42);
    Signal = MFHI; #1;
    check("mux_mfhi", dataOut, 32'd0);
    Signal = ADD; #1;
    check("mux_add", dataOut, 32'd0);

    // Non-MULTU start in IDLE
    @(negedge clk);
    start = 1'b1; Signal = SUB; dataA = 32'd2; dataB = 32'd3;
    @(negedge clk);
    check("sub_start_busy", {31'b0, busy}, 32'd0);
    start = 1'b1; Signal = 6'b011000;
    @(negedge clk);
    check("mult_signed_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("sub_start_lo", lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
